mdu_divider: RTL and testbench

Iterative radix-2 restoring divider for the multiply/divide unit. It executes DIV/DIVU and produces the quotient destined for LO and the remainder destined for HI. It is the inverse-direction partner of the multiply-accumulate path: it consumes the operands and writes HI/LO, whereas the accumulate path reads HI/LO. It sits beside the multiplier and is controlled by the EX stage through a start/busy/valid handshake with flush support.

---
 rtl/mdu_divider.sv | 113 +++++++++++
 tb/tb_mdu_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// One quotient bit per cycle; sign correction and divide-by-zero override are applied in FIX.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs_mag, dvd_orig;
  logic             dvd_neg, dvs_neg, dvs_zero, sgn_mode;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             accept;

  assign accept     = (state == IDLE) && i_start && !i_cancel;
  assign dvd_mag_in = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign dvs_mag_in = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // Partial remainder gains the next dividend bit from the top of quo.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};

  always_comb begin
    q_fix = (sgn_mode && (dvd_neg ^ dvs_neg)) ? -quo : quo;
    r_fix = (sgn_mode && dvd_neg) ? -rem : rem;
    if (dvs_zero) begin
      q_fix = '1;
      r_fix = dvd_orig;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (i_cancel)                state_nxt = IDLE;
        else if (cnt == CW'(1))      state_nxt = FIX;
      end
      FIX:  state_nxt = i_cancel ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rem           <= '0;
      quo           <= '0;
      dvs_mag       <= '0;
      dvd_orig      <= '0;
      dvd_neg       <= 1'b0;
      dvs_neg       <= 1'b0;
      dvs_zero      <= 1'b0;
      sgn_mode      <= 1'b0;
      cnt           <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (accept) begin
          rem      <= '0;
          quo      <= dvd_mag_in;
          dvs_mag  <= dvs_mag_in;
          dvd_orig <= i_dividend;
          dvd_neg  <= i_signed & i_dividend[WIDTH-1];
          dvs_neg  <= i_signed & i_divisor[WIDTH-1];
          dvs_zero <= (i_divisor == '0);
          sgn_mode <= i_signed;
          cnt      <= CW'(WIDTH);
        end
        CALC: if (!i_cancel) begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - CW'(1);
        end
        // A flush in FIX leaves the previously published results untouched.
        FIX: if (!i_cancel) begin
          o_quotient    <= q_fix;
          o_remainder   <= r_fix;
          o_div_by_zero <= dvs_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed cases with literal expectations plus
// randomized back-to-back traffic checked every cycle against an arithmetic timeline model.
module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        rst_n, start, sgn, cancel;
  logic [31:0] dvd, dvs;
  logic        busy, valid, dbz;
  logic [31:0] quot, remd;

  mdu_divider #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .i_cancel(cancel),
    .o_busy(busy), .o_valid(valid), .o_quotient(quot),
    .o_remainder(remd), .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } res_t;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result straight from integer division semantics.
  function automatic res_t ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    res_t   res;
    longint sa, sb;
    if (b == 0) begin
      res.q = 32'hFFFF_FFFF; res.r = a; res.z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res.q = 32'(sa / sb); res.r = 32'(sa % sb); res.z = 1'b0;
    end else begin
      res.q = a / b; res.r = a % b; res.z = 1'b0;
    end
    return res;
  endfunction

  // Timeline model: an accepted op occupies edges acc+1..acc+34, results appear at acc+33.
  int   cyc = 0, m_acc = 0;
  bit   m_active = 0, m_valid = 0;
  res_t m_pend, m_out;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_valid = 0; m_out = '0;
    end else begin
      m_valid = 0;
      if (m_active) begin
        if (cyc == m_acc + 34)      m_active = 0;
        else if (cancel)            m_active = 0;
        else if (cyc == m_acc + 33) begin m_out = m_pend; m_valid = 1; end
      end else if (start && !cancel) begin
        m_active = 1; m_acc = cyc; m_pend = ref_div(sgn, dvd, dvs);
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy",  {31'b0, busy},  {31'b0, m_active});
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    chk("quot",  quot, m_out.q);
    chk("rem",   remd, m_out.r);
    chk("dbz",   {31'b0, dbz},   {31'b0, m_out.z});
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 100) begin tick(); n++; end
    if (m_active) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one op and check latency and result against hand-computed literals.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input bit ez);
    int n = 0;
    wait_idle();
    start = 1; sgn = s; dvd = a; dvs = b;
    @(posedge clk); #2;
    start = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 60);
    chk("latency", n, 34);
    chk("lit_q", quot, eq);
    chk("lit_r", remd, er);
    chk("lit_z", {31'b0, dbz}, {31'b0, ez});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t p;
    rst_n = 0; start = 0; sgn = 0; cancel = 0; dvd = 0; dvs = 0;
    @(posedge clk); #2;
    chk_en = 1;
    tick();
    chk("rst_q", quot, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1;

    // Pin the model with hand-derived values.
    p = ref_div(1, 32'hFFFF_FFF9, 32'd2);
    chk("model_q", p.q, 32'hFFFF_FFFD);
    chk("model_r", p.r, 32'hFFFF_FFFF);
    p = ref_div(1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_ovf", p.q, 32'h8000_0000);

    do_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    do_op(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    do_op(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    do_op(1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1);
    do_op(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Cancel mid-op; a start while busy is ignored.
    wait_idle();
    start = 1; sgn = 0; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #2;
    start = 0;
    repeat (4) tick();
    start = 1; dvd = 32'd55; dvs = 32'd5;
    tick();
    start = 0;
    repeat (4) tick();
    cancel = 1;
    @(posedge clk); #2;
    cancel = 0;
    @(negedge clk);
    chk("cancel_busy", {31'b0, busy}, 32'h0);
    chk("cancel_hold_q", quot, 32'd3);
    repeat (40) tick();

    // Start together with cancel in IDLE is discarded.
    start = 1; cancel = 1;
    tick();
    start = 0; cancel = 0;
    @(negedge clk);
    chk("startcancel_busy", {31'b0, busy}, 32'h0);

    // Reset in the middle of an operation.
    tick();
    start = 1; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #2;
    start = 0;
    repeat (19) tick();
    rst_n = 0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("midrst_q", quot, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1;
    tick();
    do_op(0, 32'd50, 32'd5, 32'd10, 32'd0, 0);

    // Random traffic: start held mostly high for back-to-back issue, rare flushes.
    repeat (1500) begin
      start  = ($urandom_range(0, 3) != 0);
      sgn    = 1'($urandom_range(0, 1));
      dvd    = pick();
      dvs    = pick();
      cancel = ($urandom_range(0, 99) == 0);
      tick();
    end
    start = 0; cancel = 0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
